// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Shares one register write port among three requesters with round-robin
//   arbitration. A requester is eligible when its Req bit is high and it was
//   not acknowledged in the same cycle. The winner is acknowledged one cycle
//   later, and its address and data are registered onto the write port.
//   Writes to address 0 are acknowledged normally but are never enabled.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   Req[2:0]      per-requester write request
//   Req_AddrN     requester N target address
//   Req_DataN     requester N write data
//   Ack[2:0]      one-hot, single-cycle acknowledge to the winner
//   Wr_En         write enable; low for no grant or for address 0
//   Wr_Addr       registered write address (holds when there is no grant)
//   Wr_Data       registered write data (holds when there is no grant)
//   Conflict_Cnt  saturating count of cycles with two or more eligible
`timescale 1ns/1ps
module reg_write_arbiter #(
  parameter int BIT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            Req,
  input  logic [ADDR_WIDTH-1:0] Req_Addr0,
  input  logic [ADDR_WIDTH-1:0] Req_Addr1,
  input  logic [ADDR_WIDTH-1:0] Req_Addr2,
  input  logic [BIT_WIDTH-1:0]  Req_Data0,
  input  logic [BIT_WIDTH-1:0]  Req_Data1,
  input  logic [BIT_WIDTH-1:0]  Req_Data2,
  output logic [2:0]            Ack,
  output logic                  Wr_En,
  output logic [ADDR_WIDTH-1:0] Wr_Addr,
  output logic [BIT_WIDTH-1:0]  Wr_Data,
  output logic [15:0]           Conflict_Cnt
);

  logic [1:0]            last;
  logic [2:0]            elig;
  logic [1:0]            start;
  logic [1:0]            cand;
  logic [1:0]            win;
  logic                  found;
  logic                  multi;
  logic [2:0]            win_oh;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [BIT_WIDTH-1:0]  sel_data;

  // A requester acknowledged this cycle sits out this cycle's arbitration.
  // Its Req is still high because it only drops after it sees Ack.
  assign elig  = Req & ~Ack;
  assign multi = (elig[0] & elig[1]) | (elig[0] & elig[2]) | (elig[1] & elig[2]);

  // Round-robin search that starts one index past the last winner.
  always_comb begin
    case (last)
      2'd0:    start = 2'd1;
      2'd1:    start = 2'd2;
      default: start = 2'd0;
    endcase
    found = 1'b0;
    win   = last;
    cand  = start;
    for (int k = 0; k < 3; k++) begin
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
    end
  end

  always_comb begin
    case (win)
      2'd0: begin
        win_oh   = 3'b001;
        sel_addr = Req_Addr0;
        sel_data = Req_Data0;
      end
      2'd1: begin
        win_oh   = 3'b010;
        sel_addr = Req_Addr1;
        sel_data = Req_Data1;
      end
      default: begin
        win_oh   = 3'b100;
        sel_addr = Req_Addr2;
        sel_data = Req_Data2;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Ack          <= 3'b000;
      Wr_En        <= 1'b0;
      Wr_Addr      <= '0;
      Wr_Data      <= '0;
      Conflict_Cnt <= 16'h0000;
      last         <= 2'd2;  // gives requester 0 first priority after reset
    end else begin
      Ack   <= found ? win_oh : 3'b000;
      Wr_En <= found && (sel_addr != '0);
      if (found) begin
        Wr_Addr <= sel_addr;
        Wr_Data <= sel_data;
        last    <= win;
      end
      if (multi && (Conflict_Cnt != 16'hFFFF))
        Conflict_Cnt <= Conflict_Cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
`timescale 1ns/1ps
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  Req = 3'b000;
  logic [4:0]  Req_Addr0 = '0, Req_Addr1 = '0, Req_Addr2 = '0;
  logic [31:0] Req_Data0 = '0, Req_Data1 = '0, Req_Data2 = '0;
  logic [2:0]  Ack;
  logic        Wr_En;
  logic [4:0]  Wr_Addr;
  logic [31:0] Wr_Data;
  logic [15:0] Conflict_Cnt;

  int compared   = 0;
  int mismatched = 0;

  reg_write_arbiter #(.BIT_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .Req(Req),
    .Req_Addr0(Req_Addr0), .Req_Addr1(Req_Addr1), .Req_Addr2(Req_Addr2),
    .Req_Data0(Req_Data0), .Req_Data1(Req_Data1), .Req_Data2(Req_Data2),
    .Ack(Ack), .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
    .Conflict_Cnt(Conflict_Cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Holds reset for two edges; released 1ns after an edge so the next edge
  // is the first one that can grant.
  task automatic apply_reset;
    rst = 1'b0;
    tick;
    tick;
    rst = 1'b1;
  endtask

  task automatic set_reqs(input logic [4:0] a0, a1, a2, input logic [31:0] d0, d1, d2);
    Req_Addr0 = a0; Req_Addr1 = a1; Req_Addr2 = a2;
    Req_Data0 = d0; Req_Data1 = d1; Req_Data2 = d2;
  endtask

  task automatic test_reset;
    Req = 3'b111;
    set_reqs(5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
    rst = 1'b0;
    tick;
    tick;
    compared++; if (Ack !== 3'b000) begin mismatched++; $display("FAIL reset_ack got %b want 000", Ack); end
    compared++; if (Wr_En !== 1'b0) begin mismatched++; $display("FAIL reset_wren got %b want 0", Wr_En); end
    compared++; if (Wr_Addr !== 5'd0) begin mismatched++; $display("FAIL reset_addr got %0d want 0", Wr_Addr); end
    compared++; if (Wr_Data !== 32'h0) begin mismatched++; $display("FAIL reset_data got %h want 0", Wr_Data); end
    compared++; if (Conflict_Cnt !== 16'h0) begin mismatched++; $display("FAIL reset_cnt got %0d want 0", Conflict_Cnt); end
    Req = 3'b000;
  endtask

  task automatic test_single;
    Req = 3'b001;
    set_reqs(5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0);
    apply_reset;
    tick;
    compared++; if (Ack !== 3'b001) begin mismatched++; $display("FAIL single_ack1 got %b want 001", Ack); end
    compared++; if (Wr_En !== 1'b1) begin mismatched++; $display("FAIL single_wren1 got %b want 1", Wr_En); end
    compared++; if (Wr_Addr !== 5'd5) begin mismatched++; $display("FAIL single_addr1 got %0d want 5", Wr_Addr); end
    compared++; if (Wr_Data !== 32'hDEADBEEF) begin mismatched++; $display("FAIL single_data1 got %h want deadbeef", Wr_Data); end
    tick;
    compared++; if (Ack !== 3'b000) begin mismatched++; $display("FAIL single_ack2 got %b want 000", Ack); end
    compared++; if (Wr_En !== 1'b0) begin mismatched++; $display("FAIL single_wren2 got %b want 0", Wr_En); end
    compared++; if (Wr_Addr !== 5'd5) begin mismatched++; $display("FAIL single_hold_addr got %0d want 5", Wr_Addr); end
    compared++; if (Wr_Data !== 32'hDEADBEEF) begin mismatched++; $display("FAIL single_hold_data got %h want deadbeef", Wr_Data); end
    tick;
    compared++; if (Ack !== 3'b001) begin mismatched++; $display("FAIL single_regrant got %b want 001", Ack); end
    compared++; if (Conflict_Cnt !== 16'd0) begin mismatched++; $display("FAIL single_cnt got %0d want 0", Conflict_Cnt); end
    Req = 3'b000;
    tick;
  endtask

  task automatic test_rotate;
    logic [2:0]  ack_tbl  [6];
    logic [4:0]  addr_tbl [6];
    logic [31:0] data_tbl [6];
    ack_tbl  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    addr_tbl = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
    data_tbl = '{32'hA0, 32'hA1, 32'hA2, 32'hA0, 32'hA1, 32'hA2};
    Req = 3'b111;
    set_reqs(5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2);
    apply_reset;
    for (int k = 0; k < 6; k++) begin
      tick;
      compared++; if (Ack !== ack_tbl[k]) begin mismatched++; $display("FAIL rot_ack[%0d] got %b want %b", k, Ack, ack_tbl[k]); end
      compared++; if (Wr_Addr !== addr_tbl[k]) begin mismatched++; $display("FAIL rot_addr[%0d] got %0d want %0d", k, Wr_Addr, addr_tbl[k]); end
      compared++; if (Wr_Data !== data_tbl[k]) begin mismatched++; $display("FAIL rot_data[%0d] got %h want %h", k, Wr_Data, data_tbl[k]); end
      compared++; if (Wr_En !== 1'b1) begin mismatched++; $display("FAIL rot_wren[%0d] got %b want 1", k, Wr_En); end
      compared++; if (Conflict_Cnt !== 16'(k + 1)) begin mismatched++; $display("FAIL rot_cnt[%0d] got %0d want %0d", k, Conflict_Cnt, k + 1); end
    end
    Req = 3'b000;
    tick;
  endtask

  task automatic test_zero_addr;
    Req = 3'b010;
    set_reqs(5'd7, 5'd0, 5'd9, 32'h0, 32'h12345678, 32'h0);
    apply_reset;
    tick;
    compared++; if (Ack !== 3'b010) begin mismatched++; $display("FAIL zero_ack got %b want 010", Ack); end
    compared++; if (Wr_En !== 1'b0) begin mismatched++; $display("FAIL zero_wren got %b want 0", Wr_En); end
    compared++; if (Wr_Addr !== 5'd0) begin mismatched++; $display("FAIL zero_addr got %0d want 0", Wr_Addr); end
    compared++; if (Wr_Data !== 32'h12345678) begin mismatched++; $display("FAIL zero_data got %h want 12345678", Wr_Data); end
    Req = 3'b000;
    tick;
  endtask

  task automatic test_withdraw;
    // Requester 1 withdraws right before its turn; nothing else eligible.
    Req = 3'b011;
    set_reqs(5'd1, 5'd2, 5'd3, 32'hB0, 32'hB1, 32'hB2);
    apply_reset;
    tick;
    compared++; if (Ack !== 3'b001) begin mismatched++; $display("FAIL wd_first got %b want 001", Ack); end
    Req = 3'b001;
    tick;
    compared++; if (Ack !== 3'b000) begin mismatched++; $display("FAIL wd_none_ack got %b want 000", Ack); end
    compared++; if (Wr_En !== 1'b0) begin mismatched++; $display("FAIL wd_none_wren got %b want 0", Wr_En); end
    Req = 3'b000;
    // Requester 1 withdraws; grant passes on to requester 2.
    Req = 3'b111;
    apply_reset;
    tick;
    compared++; if (Ack !== 3'b001) begin mismatched++; $display("FAIL wd2_first got %b want 001", Ack); end
    Req = 3'b101;
    tick;
    compared++; if (Ack !== 3'b100) begin mismatched++; $display("FAIL wd2_pass_ack got %b want 100", Ack); end
    compared++; if (Wr_Addr !== 5'd3) begin mismatched++; $display("FAIL wd2_pass_addr got %0d want 3", Wr_Addr); end
    compared++; if (Conflict_Cnt !== 16'd1) begin mismatched++; $display("FAIL wd2_cnt got %0d want 1", Conflict_Cnt); end
    Req = 3'b000;
    tick;
  endtask

  task automatic test_mid_reset;
    Req = 3'b111;
    set_reqs(5'd1, 5'd2, 5'd3, 32'hC0, 32'hC1, 32'hC2);
    apply_reset;
    tick;
    tick;
    compared++; if (Ack !== 3'b010) begin mismatched++; $display("FAIL mr_pre_ack got %b want 010", Ack); end
    rst = 1'b0;
    #1;
    compared++; if (Ack !== 3'b000) begin mismatched++; $display("FAIL mr_async_ack got %b want 000", Ack); end
    compared++; if (Wr_En !== 1'b0) begin mismatched++; $display("FAIL mr_async_wren got %b want 0", Wr_En); end
    compared++; if (Conflict_Cnt !== 16'd0) begin mismatched++; $display("FAIL mr_async_cnt got %0d want 0", Conflict_Cnt); end
    #2;
    rst = 1'b1;
    tick;
    compared++; if (Ack !== 3'b001) begin mismatched++; $display("FAIL mr_first_ack got %b want 001", Ack); end
    compared++; if (Conflict_Cnt !== 16'd1) begin mismatched++; $display("FAIL mr_first_cnt got %0d want 1", Conflict_Cnt); end
    Req = 3'b000;
    tick;
  endtask

  task automatic test_saturate;
    Req = 3'b111;
    set_reqs(5'd1, 5'd2, 5'd3, 32'hD0, 32'hD1, 32'hD2);
    apply_reset;
    repeat (65534) tick;
    compared++; if (Conflict_Cnt !== 16'hFFFE) begin mismatched++; $display("FAIL sat_pre got %h want fffe", Conflict_Cnt); end
    repeat (6) tick;
    compared++; if (Conflict_Cnt !== 16'hFFFF) begin mismatched++; $display("FAIL sat_hold got %h want ffff", Conflict_Cnt); end
    Req = 3'b000;
    tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_rotate;
    test_zero_addr;
    test_withdraw;
    test_mid_reset;
    test_saturate;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter BIT_WIDTH, default 32: width of the write data.
REQ-002 Parameter ADDR_WIDTH, default 5: width of the register write address.
REQ-003 Port clk  input  1  clock; all state changes on the rising edge.
REQ-004 Port rst  input  1  reset; asynchronous, active-low.
REQ-005 Port Req  input  3  per-requester write request; bit i is requester i.
REQ-006 Port Req_Addr0/1/2  input  ADDR_WIDTH each  target register address of requester i.
REQ-007 Port Req_Data0/1/2  input  BIT_WIDTH each  write data of requester i.
REQ-008 Port Ack  output  3  one-hot, one-cycle acknowledge to the winning requester.
REQ-009 Port Wr_En  output  1  write enable to the shared register write port.
REQ-010 Port Wr_Addr  output  ADDR_WIDTH  registered write address.
REQ-011 Port Wr_Data  output  BIT_WIDTH  registered write data.
REQ-012 Port Conflict_Cnt  output  16  saturating count of contended cycles.

Function
REQ-013 The block SHALL share one register write port among 3 requesters, granting at most one per cycle.
REQ-014 Requester i is eligible in a cycle iff Req[i]=1 and Ack[i]=0 in that same cycle; a just-acknowledged requester is excluded for one cycle.
REQ-015 Arbitration SHALL be round-robin: search starts at (Last+1) mod 3, where Last is the 2-bit index of the most recent grant; first eligible index wins.
REQ-016 Last SHALL update to the winner index only on cycles with a grant; idle cycles leave it unchanged.
REQ-017 Latency: eligibility sampled in cycle N; at edge ending N, Ack[winner]=1 and Wr_Addr/Wr_Data load the winner's inputs, all visible in cycle N+1.
REQ-018 Ack SHALL be exactly one cycle wide and all-zero on cycles following no grant.
REQ-019 Wr_En SHALL be 1 in cycle N+1 iff a grant occurred and the winner's address is nonzero.
REQ-020 A granted request to address 0 SHALL be acknowledged normally but produce Wr_En=0 (discarded write to $zero).
REQ-021 With no grant, Wr_En=0 and Wr_Addr/Wr_Data hold their previous values.
REQ-022 Requesters SHALL hold Req, address and data stable until Ack; deasserting Req before Ack withdraws the request without error.
REQ-023 Conflict_Cnt SHALL increment by 1 on each cycle with two or more eligible requesters, saturating at 16'hFFFF (no wrap).
REQ-024 Grant, Last update and counter update occurring on the same edge SHALL be applied together; no priority among them.

Reset
REQ-025 While rst=0: Ack=3'b000, Wr_En=0, Wr_Addr=0, Wr_Data=0, Conflict_Cnt=0, Last=2 (so requester 0 has first priority after reset).
REQ-026 Reset asserted mid-operation SHALL clear all state immediately; in-flight grants are lost and not re-issued.
REQ-027 First grant SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-028 Reset then Req=3'b001, Req_Addr0=5, Req_Data0=32'hDEADBEEF held -> next cycle Ack=001, Wr_En=1, Wr_Addr=5, Wr_Data=32'hDEADBEEF; following cycle Ack=000, Wr_En=0; then regrant cycle after (Req still held).
REQ-029 Reset then Req=3'b111 held continuously, distinct addrs -> grants rotate 0,1,2,0,... one per cycle; Conflict_Cnt increments every cycle eligible count >=2.
REQ-030 Req=3'b010 with Req_Addr1=0, Req_Data1=32'h12345678 -> Ack=010, Wr_En=0, Wr_Addr=0, Wr_Data=32'h12345678.
REQ-031 Force contention for 65540 cycles -> Conflict_Cnt stops at 16'hFFFF.
REQ-032 rst pulsed low between grant edge and next edge with Req=111 -> Ack, Wr_En, Conflict_Cnt go 0 asynchronously; after release first grant goes to requester 0.
REQ-033 Req bit dropped one cycle before expected grant -> no Ack to that requester; grant passes to next eligible or none.
